// File: rtl/cache_pkg.sv
// Shared definitions for the cache data array: fill FSM encoding and default geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } fill_state_e;

    localparam int CDA_NUM_WAYS        = 4;
    localparam int CDA_NUM_SETS        = 16;
    localparam int CDA_LINE_BYTES      = 64;
    localparam int CDA_BEAT_BYTES      = 16;
    localparam int CDA_NUM_WAYS_LOG    = $clog2(CDA_NUM_WAYS);
    localparam int CDA_NUM_SETS_LOG    = $clog2(CDA_NUM_SETS);
    localparam int CDA_CACHE_LINE_BITS = CDA_LINE_BYTES * 8;
    localparam int CDA_NUM_BEATS       = CDA_LINE_BYTES / CDA_BEAT_BYTES;

    // Counter width that stays at least one bit wide for single-beat lines.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_data_way.sv
// One cache way: NUM_SETS lines, 1R1W, per-byte write enables, registered read.
// Define CACHE_DATA_BYPASS_EN to forward same-cycle writes into the read result.
module cache_data_way
    import cache_pkg::*;
#(
    parameter int NUM_SETS   = CDA_NUM_SETS,
    parameter int LINE_BYTES = CDA_LINE_BYTES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rd_en,
    input  logic [$clog2(NUM_SETS)-1:0] rd_set,
    output logic [LINE_BYTES*8-1:0]   rd_data,
    input  logic [$clog2(NUM_SETS)-1:0] wr_set,
    input  logic [LINE_BYTES-1:0]     wr_byte_en,
    input  logic [LINE_BYTES*8-1:0]   wr_data
);

    logic [LINE_BYTES*8-1:0] mem [NUM_SETS];

    // NOTE: the storage array has no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (wr_byte_en[b]) begin
                mem[wr_set][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
`ifdef CACHE_DATA_BYPASS_EN
            for (int b = 0; b < LINE_BYTES; b++) begin
                rd_data[b*8 +: 8] <= (wr_byte_en[b] && (wr_set == rd_set)) ?
                                     wr_data[b*8 +: 8] : mem[rd_set][b*8 +: 8];
            end
`else
            rd_data <= mem[rd_set];
`endif
        end
    end

endmodule

// File: rtl/cache_data_array.sv
// Cache data array: per-way storage, byte-masked stores and a beat-wise line fill engine.
// Read/write collision forwarding is enabled by defining CACHE_DATA_BYPASS_EN.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int NUM_WAYS         = CDA_NUM_WAYS,
    parameter int NUM_SETS         = CDA_NUM_SETS,
    parameter int CACHE_LINE_BYTES = CDA_LINE_BYTES,
    parameter int FILL_BEAT_BYTES  = CDA_BEAT_BYTES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 access_en,
    input  logic [$clog2(NUM_WAYS)-1:0]          access_way_idx,
    input  logic [$clog2(NUM_SETS)-1:0]          access_set_idx,
    output logic                                 access_valid,
    output logic [CACHE_LINE_BYTES*8-1:0]        access_data,
    input  logic                                 store_en,
    output logic                                 store_ready,
    input  logic [$clog2(NUM_WAYS)-1:0]          store_way_idx,
    input  logic [$clog2(NUM_SETS)-1:0]          store_set_idx,
    input  logic [CACHE_LINE_BYTES-1:0]          store_byte_en,
    input  logic [CACHE_LINE_BYTES*8-1:0]        store_data,
    input  logic                                 fill_start,
    input  logic [$clog2(NUM_WAYS)-1:0]          fill_way_idx,
    input  logic [$clog2(NUM_SETS)-1:0]          fill_set_idx,
    output logic                                 fill_ready,
    input  logic                                 fill_beat_valid,
    input  logic [FILL_BEAT_BYTES*8-1:0]         fill_beat_data,
    output logic                                 fill_done,
    output logic                                 fill_busy
);

    localparam int NUM_WAYS_LOG    = $clog2(NUM_WAYS);
    localparam int NUM_SETS_LOG    = $clog2(NUM_SETS);
    localparam int CACHE_LINE_BITS = CACHE_LINE_BYTES * 8;
    localparam int NUM_BEATS       = CACHE_LINE_BYTES / FILL_BEAT_BYTES;
    localparam int BEAT_BITS       = FILL_BEAT_BYTES * 8;
    localparam int BEAT_CNT_W      = cnt_width(NUM_BEATS);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BEATS - 1);

    fill_state_e                         state, state_next;
    logic [BEAT_CNT_W-1:0]               beat_cnt;
    logic [NUM_WAYS_LOG-1:0]             fill_way_q;
    logic [NUM_SETS_LOG-1:0]             fill_set_q;
    logic [NUM_BEATS-1:0][BEAT_BITS-1:0] line_buf;
    logic                                commit_we;

    logic [NUM_WAYS_LOG-1:0]             wr_way;
    logic [NUM_SETS_LOG-1:0]             wr_set;
    logic [CACHE_LINE_BYTES-1:0]         wr_mask;
    logic [CACHE_LINE_BITS-1:0]          wr_data;
    logic [NUM_WAYS_LOG-1:0]             access_way_q;
    logic [CACHE_LINE_BITS-1:0]          way_rd_data [NUM_WAYS];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_next  = state;
        commit_we   = 1'b0;
        fill_ready  = 1'b0;
        fill_busy   = 1'b0;
        store_ready = 1'b1;
        case (state)
            IDLE:   if (fill_start) state_next = FILL;
            FILL: begin
                fill_ready = rst_n;
                fill_busy  = rst_n;
                if (fill_beat_valid && (beat_cnt == LAST_BEAT)) state_next = COMMIT;
            end
            COMMIT: begin
                // Outputs are qualified by rst_n so a reset in this cycle suppresses the write.
                commit_we   = rst_n;
                fill_busy   = rst_n;
                store_ready = !rst_n;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fill_done = commit_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && fill_start) begin
                beat_cnt <= '0;
            end else if (state == FILL && fill_beat_valid) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && fill_start) begin
            fill_way_q <= fill_way_idx;
            fill_set_q <= fill_set_idx;
        end
        if (state == FILL && fill_beat_valid) begin
            line_buf[beat_cnt] <= fill_beat_data;
        end
    end

    // Single shared write port: the commit owns it in COMMIT, stores are held off then.
    always_comb begin
        wr_way  = store_way_idx;
        wr_set  = store_set_idx;
        wr_mask = (store_en && store_ready) ? store_byte_en : '0;
        wr_data = store_data;
        if (commit_we) begin
            wr_way  = fill_way_q;
            wr_set  = fill_set_q;
            wr_mask = '1;
            wr_data = line_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            access_valid <= 1'b0;
            access_way_q <= '0;
        end else begin
            access_valid <= access_en;
            if (access_en) access_way_q <= access_way_idx;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        cache_data_way #(
            .NUM_SETS   (NUM_SETS),
            .LINE_BYTES (CACHE_LINE_BYTES)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_en      (access_en && (access_way_idx == NUM_WAYS_LOG'(w))),
            .rd_set     (access_set_idx),
            .rd_data    (way_rd_data[w]),
            .wr_set     (wr_set),
            .wr_byte_en ((wr_way == NUM_WAYS_LOG'(w)) ? wr_mask : '0),
            .wr_data    (wr_data)
        );
    end

    // Only the addressed way updates its read register, so the mux holds the last line.
    assign access_data = way_rd_data[access_way_q];

endmodule

// File: tb/tb_cache_data_array.sv
// Directed self-checking bench for cache_data_array at 4 ways x 16 sets x 64B lines, 16B beats.
module tb_cache_data_array;
    import cache_pkg::*;

    localparam int LB   = 64;
    localparam int LBIT = LB * 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            access_en;
    logic [1:0]      access_way_idx;
    logic [3:0]      access_set_idx;
    logic            access_valid;
    logic [LBIT-1:0] access_data;
    logic            store_en;
    logic            store_ready;
    logic [1:0]      store_way_idx;
    logic [3:0]      store_set_idx;
    logic [LB-1:0]   store_byte_en;
    logic [LBIT-1:0] store_data;
    logic            fill_start;
    logic [1:0]      fill_way_idx;
    logic [3:0]      fill_set_idx;
    logic            fill_ready;
    logic            fill_beat_valid;
    logic [127:0]    fill_beat_data;
    logic            fill_done;
    logic            fill_busy;

    int errors = 0;
    int checks = 0;

    logic [LBIT-1:0] line25, line00, line37, line13, line32, merged;

    cache_data_array dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .access_en       (access_en),
        .access_way_idx  (access_way_idx),
        .access_set_idx  (access_set_idx),
        .access_valid    (access_valid),
        .access_data     (access_data),
        .store_en        (store_en),
        .store_ready     (store_ready),
        .store_way_idx   (store_way_idx),
        .store_set_idx   (store_set_idx),
        .store_byte_en   (store_byte_en),
        .store_data      (store_data),
        .fill_start      (fill_start),
        .fill_way_idx    (fill_way_idx),
        .fill_set_idx    (fill_set_idx),
        .fill_ready      (fill_ready),
        .fill_beat_valid (fill_beat_valid),
        .fill_beat_data  (fill_beat_data),
        .fill_done       (fill_done),
        .fill_busy       (fill_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LBIT-1:0] obs, input logic [LBIT-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LBIT-1:0] pat(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {{16{b3}}, {16{b2}}, {16{b1}}, {16{b0}}};
    endfunction

    task automatic do_read(input logic [1:0] way, input logic [3:0] set);
        access_en      = 1'b1;
        access_way_idx = way;
        access_set_idx = set;
        tick();
        access_en = 1'b0;
    endtask

    task automatic do_store(input logic [1:0] way, input logic [3:0] set,
                            input logic [LB-1:0] mask, input logic [LBIT-1:0] data);
        store_en      = 1'b1;
        store_way_idx = way;
        store_set_idx = set;
        store_byte_en = mask;
        store_data    = data;
        tick();
        store_en = 1'b0;
    endtask

    task automatic start_fill(input logic [1:0] way, input logic [3:0] set);
        fill_start   = 1'b1;
        fill_way_idx = way;
        fill_set_idx = set;
        tick();
        fill_start = 1'b0;
    endtask

    // Leaves the DUT in its commit cycle after the fourth beat.
    task automatic fill_beats(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bytes [4];
        bytes = '{b0, b1, b2, b3};
        for (int k = 0; k < 4; k++) begin
            fill_beat_valid = 1'b1;
            fill_beat_data  = {16{bytes[k]}};
            tick();
            if (k < 3) check($sformatf("fill_done_early_beat%0d", k), LBIT'(fill_done), LBIT'(0));
        end
        fill_beat_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        access_en = 1'b0; access_way_idx = '0; access_set_idx = '0;
        store_en = 1'b0; store_way_idx = '0; store_set_idx = '0;
        store_byte_en = '0; store_data = '0;
        fill_start = 1'b0; fill_way_idx = '0; fill_set_idx = '0;
        fill_beat_valid = 1'b0; fill_beat_data = '0;
        tick();
        tick();

        check("rst_store_ready",  LBIT'(store_ready),  LBIT'(1));
        check("rst_fill_ready",   LBIT'(fill_ready),   LBIT'(0));
        check("rst_fill_busy",    LBIT'(fill_busy),    LBIT'(0));
        check("rst_fill_done",    LBIT'(fill_done),    LBIT'(0));
        check("rst_access_valid", LBIT'(access_valid), LBIT'(0));
        check("rst_access_data",  access_data,         '0);

        rst_n = 1'b1;
        tick();
        check("post_rst_store_ready", LBIT'(store_ready), LBIT'(1));
        check("post_rst_fill_ready",  LBIT'(fill_ready),  LBIT'(0));

        // Fill way2/set5 with four beats; fill_done lands 4 edges after the start edge.
        start_fill(2'd2, 4'd5);
        check("fill_busy_in_fill",  LBIT'(fill_busy),  LBIT'(1));
        check("fill_ready_in_fill", LBIT'(fill_ready), LBIT'(1));
        fill_beats(8'h11, 8'h22, 8'h33, 8'h44);
        check("commit_fill_done",   LBIT'(fill_done),   LBIT'(1));
        check("commit_store_ready", LBIT'(store_ready), LBIT'(0));
        check("commit_fill_busy",   LBIT'(fill_busy),   LBIT'(1));
        check("commit_fill_ready",  LBIT'(fill_ready),  LBIT'(0));
        tick();
        check("idle_fill_done",   LBIT'(fill_done),   LBIT'(0));
        check("idle_fill_busy",   LBIT'(fill_busy),   LBIT'(0));
        check("idle_store_ready", LBIT'(store_ready), LBIT'(1));
        line25 = pat(8'h11, 8'h22, 8'h33, 8'h44);
        do_read(2'd2, 4'd5);
        check("fill_read_valid", LBIT'(access_valid), LBIT'(1));
        check("fill_read_data",  access_data,         line25);
        tick();
        check("idle_read_valid", LBIT'(access_valid), LBIT'(0));
        check("idle_read_hold",  access_data,         line25);

        // Single-byte store, then an all-zero-mask store that must change nothing.
        do_store(2'd2, 4'd5, 64'h1, {{63{8'hFF}}, 8'hAB});
        line25[7:0] = 8'hAB;
        do_read(2'd2, 4'd5);
        check("store_byte0", access_data, line25);
        do_store(2'd2, 4'd5, 64'h0, '0);
        do_read(2'd2, 4'd5);
        check("store_zero_mask", access_data, line25);

        // Store presented in the commit cycle is refused, then succeeds on retry.
        line00 = {64{8'hC3}};
        do_store(2'd0, 4'd0, '1, line00);
        start_fill(2'd3, 4'd7);
        fill_beats(8'h01, 8'h02, 8'h03, 8'h04);
        check("commit2_fill_done",   LBIT'(fill_done),   LBIT'(1));
        check("commit2_store_ready", LBIT'(store_ready), LBIT'(0));
        do_store(2'd0, 4'd0, 64'h1, {{63{8'h00}}, 8'h5A});
        line37 = pat(8'h01, 8'h02, 8'h03, 8'h04);
        do_read(2'd0, 4'd0);
        check("commit_store_dropped", access_data, line00);
        do_read(2'd3, 4'd7);
        check("fill2_read", access_data, line37);
        check("retry_store_ready", LBIT'(store_ready), LBIT'(1));
        do_store(2'd0, 4'd0, 64'h1, {{63{8'h00}}, 8'h5A});
        line00[7:0] = 8'h5A;
        do_read(2'd0, 4'd0);
        check("retry_store_done", access_data, line00);

        // Read and store to way1/set3 in the same cycle.
        line13 = {64{8'h10}};
        do_store(2'd1, 4'd3, '1, line13);
        merged = {{32{8'h10}}, {32{8'h20}}};
        access_en = 1'b1; access_way_idx = 2'd1; access_set_idx = 4'd3;
        store_en = 1'b1; store_way_idx = 2'd1; store_set_idx = 4'd3;
        store_byte_en = 64'h0000_0000_FFFF_FFFF; store_data = {64{8'h20}};
        tick();
        access_en = 1'b0; store_en = 1'b0;
`ifdef CACHE_DATA_BYPASS_EN
        check("collide_read", access_data, merged);
`else
        check("collide_read", access_data, line13);
`endif
        line13 = merged;
        do_read(2'd1, 4'd3);
        check("collide_reread", access_data, line13);

        // Different addresses in the same cycle do not interact.
        access_en = 1'b1; access_way_idx = 2'd2; access_set_idx = 4'd5;
        store_en = 1'b1; store_way_idx = 2'd1; store_set_idx = 4'd3;
        store_byte_en = 64'h1; store_data = {64{8'h30}};
        tick();
        access_en = 1'b0; store_en = 1'b0;
        check("no_collide_read", access_data, line25);
        line13[7:0] = 8'h30;
        do_read(2'd1, 4'd3);
        check("no_collide_store", access_data, line13);

        // Reset after three beats abandons the fill without touching the array.
        start_fill(2'd2, 4'd5);
        for (int k = 0; k < 3; k++) begin
            fill_beat_valid = 1'b1;
            fill_beat_data  = {16{8'h77 + 8'(k)}};
            tick();
        end
        fill_beat_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_fill_busy",    LBIT'(fill_busy),    LBIT'(0));
        check("midrst_fill_done",    LBIT'(fill_done),    LBIT'(0));
        check("midrst_fill_ready",   LBIT'(fill_ready),   LBIT'(0));
        check("midrst_store_ready",  LBIT'(store_ready),  LBIT'(1));
        check("midrst_access_valid", LBIT'(access_valid), LBIT'(0));
        rst_n = 1'b1;
        tick();
        tick();
        check("after_rst_fill_done", LBIT'(fill_done), LBIT'(0));
        check("after_rst_fill_busy", LBIT'(fill_busy), LBIT'(0));
        do_read(2'd2, 4'd5);
        check("abandoned_fill_line", access_data, line25);

        // fill_start during FILL is ignored; a store during FILL is overwritten by the commit.
        start_fill(2'd3, 4'd2);
        start_fill(2'd0, 4'd0);
        check("ignored_start_busy", LBIT'(fill_busy), LBIT'(1));
        do_store(2'd3, 4'd2, '1, {64{8'hEE}});
        do_read(2'd3, 4'd2);
        check("store_during_fill", access_data, {64{8'hEE}});
        fill_beats(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        check("commit3_fill_done", LBIT'(fill_done), LBIT'(1));
        tick();
        line32 = pat(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        do_read(2'd3, 4'd2);
        check("commit_original_target", access_data, line32);
        do_read(2'd0, 4'd0);
        check("ignored_target_intact", access_data, line00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_data_array.md
CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of ways.
REQ-002 SHALL have parameter NUM_SETS, default 16, sets per way.
REQ-003 SHALL have parameter CACHE_LINE_BYTES, default 64, line size in bytes.
REQ-004 SHALL have parameter FILL_BEAT_BYTES, default 16, fill-bus beat size; CACHE_LINE_BYTES SHALL be an integer multiple of it.
REQ-005 SHALL derive NUM_WAYS_LOG = $clog2(NUM_WAYS), NUM_SETS_LOG = $clog2(NUM_SETS), CACHE_LINE_BITS = CACHE_LINE_BYTES*8, NUM_BEATS = CACHE_LINE_BYTES/FILL_BEAT_BYTES.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset. One clock; reset is synchronous and active-low.
REQ-007 access_en in 1; access_way_idx in NUM_WAYS_LOG; access_set_idx in NUM_SETS_LOG; access_valid out 1; access_data out CACHE_LINE_BITS.
REQ-008 store_en in 1; store_ready out 1; store_way_idx in NUM_WAYS_LOG; store_set_idx in NUM_SETS_LOG; store_byte_en in CACHE_LINE_BYTES; store_data in CACHE_LINE_BITS.
REQ-009 fill_start in 1; fill_way_idx in NUM_WAYS_LOG; fill_set_idx in NUM_SETS_LOG; fill_ready out 1; fill_beat_valid in 1; fill_beat_data in FILL_BEAT_BYTES*8; fill_done out 1; fill_busy out 1.

Function
REQ-010 Read: access_en in cycle N SHALL give access_valid=1 and line (way, set) on access_data in N+1; with access_en low, access_valid=0 and access_data holds last value.
REQ-011 Store: when store_en && store_ready, bytes with store_byte_en[b]=1 SHALL be written at the clock edge; bytes with store_byte_en[b]=0 unchanged; all-zero mask is a no-op.
REQ-012 Fill FSM SHALL have states IDLE, FILL, COMMIT; fill_busy=1 in FILL and COMMIT.
REQ-013 IDLE: fill_start SHALL latch fill_way_idx/fill_set_idx, clear beat counter, go to FILL.
REQ-014 FILL: fill_ready=1; each fill_beat_valid cycle SHALL place the beat in line-buffer bytes [k*FILL_BEAT_BYTES +: FILL_BEAT_BYTES], k = counter, then increment; beat k=NUM_BEATS-1 SHALL go to COMMIT.
REQ-015 COMMIT (one cycle): full line SHALL be written to latched way/set; fill_done=1 this cycle only; next state IDLE.
REQ-016 fill_start in FILL/COMMIT SHALL be ignored; fill_beat_valid outside FILL SHALL be ignored.
REQ-017 store_ready SHALL be 0 in COMMIT, 1 otherwise; stores in FILL to the line being filled SHALL write the array and be overwritten by the commit.
REQ-018 NUM_BEATS=1: single beat SHALL go FILL to COMMIT directly.
REQ-019 Read same cycle as write to same way/set: behaviour per REQ-023/REQ-024; different addresses SHALL not interact.

Reset
REQ-020 Synchronous rst_n low SHALL set state IDLE, beat counter 0, access_valid 0, access_data 0, fill_done 0, fill_busy 0.
REQ-021 Reset mid-fill SHALL abandon the fill with no array write; array contents SHALL not be reset.
REQ-022 store_ready SHALL be 1 and fill_ready 0 during and after reset.

Configuration
REQ-023 With CACHE_DATA_BYPASS_EN defined: read colliding with a store or commit SHALL return the merged new data in N+1.
REQ-024 Without CACHE_DATA_BYPASS_EN: colliding read SHALL return prior contents; no bypass logic built.

Structure
REQ-025 Fill-state encoding and the derived-width localparams SHALL live in shared package cache_pkg.
REQ-026 Storage SHALL be sub-module cache_data_way: one per way, 1R1W, NUM_SETS x CACHE_LINE_BITS, per-byte write enables, 1-cycle registered read.

Verification (NUM_WAYS=4, NUM_SETS=16, CACHE_LINE_BYTES=64, FILL_BEAT_BYTES=16)
REQ-027 Fill way2/set5 with beats 0x11..,0x22..,0x33..,0x44.. -> fill_done once, 4 cycles after last fill_start; read way2/set5 -> bytes 0-15=0x11 .. 48-63=0x44, access_valid one cycle.
REQ-028 Store way2/set5, byte_en=0x1, data byte0=0xAB -> read gives byte0=0xAB, bytes 1-63 unchanged.
REQ-029 Store in COMMIT cycle -> store_ready=0, store not performed; retry next cycle succeeds.
REQ-030 Read and store way1/set3 same cycle -> new data with CACHE_DATA_BYPASS_EN, old data without.
REQ-031 rst_n low after beat 2 -> fill_busy=0, no fill_done, way/set contents unchanged.
REQ-032 fill_start during FILL with other way/set -> ignored; commit goes to original way/set.
